// File: rtl/hamming_frame_serializer.sv
// Buffers 12-bit Hamming codewords and shifts them out MSB-first as framed serial bits.
// Define SER_SYNC_HDR_EN to prefix each frame with the 8-bit SYNC_WORD header.
module hamming_frame_serializer #(
    parameter int CLK_DIV    = 100,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_BITS   = 2
`ifdef SER_SYNC_HDR_EN
    ,
    parameter logic [7:0] SYNC_WORD = 8'hA5
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [11:0]                   cw_in,
    input  logic                          cw_valid,
    output logic                          tx_bit,
    output logic                          tx_en,
    output logic                          bit_strobe,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0]     CNT_LAST = 16'(CLK_DIV - 1);
    localparam logic [7:0]      GAP_LAST = 8'(GAP_BITS - 1);
    localparam logic [AW:0]     LVL_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_GAP  = 2'd2
`ifdef SER_SYNC_HDR_EN
        ,
        S_SYNC = 2'd3
`endif
    } state_t;

    logic [11:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   level_q;
    logic          overflow_q;
    logic          full, empty, push, pop;
    logic [11:0]   head;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    idx_q, idx_d;
    logic [11:0]   sh_q, sh_d;
    logic          wrap;
`ifdef SER_SYNC_HDR_EN
    logic [7:0]    sync_q, sync_d;
`endif

    // Full is taken from pre-edge occupancy, so a same-edge pop never rescues a write.
    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign push  = cw_valid & ~full;
    assign head  = mem_q[rptr_q];
    assign wrap  = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= cw_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            level_q <= level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (cw_valid && full) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
`ifdef SER_SYNC_HDR_EN
            sync_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
`ifdef SER_SYNC_HDR_EN
            sync_q  <= sync_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        pop     = 1'b0;
`ifdef SER_SYNC_HDR_EN
        sync_d  = sync_q;
`endif
        if (state_q != S_IDLE) cnt_d = wrap ? 16'd0 : cnt_q + 16'd1;
        case (state_q)
            S_IDLE: if (!empty) begin
                cnt_d = '0;
                idx_d = '0;
`ifdef SER_SYNC_HDR_EN
                state_d = S_SYNC;
                sync_d  = SYNC_WORD;
`else
                state_d = S_DATA;
                pop     = 1'b1;
                sh_d    = head;
`endif
            end
`ifdef SER_SYNC_HDR_EN
            S_SYNC: if (wrap) begin
                if (idx_q == 8'd7) begin
                    idx_d = '0;
                    if (!empty) begin
                        state_d = S_DATA;
                        pop     = 1'b1;
                        sh_d    = head;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    sync_d = {sync_q[6:0], 1'b0};
                    idx_d  = idx_q + 8'd1;
                end
            end
`endif
            // Back-to-back words stay in DATA so tx_en never drops inside a frame.
            S_DATA: if (wrap) begin
                if (idx_q == 8'd11) begin
                    idx_d = '0;
                    if (!empty) begin
                        pop  = 1'b1;
                        sh_d = head;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    sh_d  = {sh_q[10:0], 1'b0};
                    idx_d = idx_q + 8'd1;
                end
            end
            S_GAP: if (wrap) begin
                if (idx_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        bit_strobe = busy && (cnt_q == '0);
        tx_en      = 1'b0;
        tx_bit     = 1'b0;
        case (state_q)
            S_DATA: begin
                tx_en  = 1'b1;
                tx_bit = sh_q[11];
            end
`ifdef SER_SYNC_HDR_EN
            S_SYNC: begin
                tx_en  = 1'b1;
                tx_bit = sync_q[7];
            end
`endif
            default: ;
        endcase
    end

    assign overflow   = overflow_q;
    assign fifo_level = level_q;
endmodule

// File: tb/tb_hamming_frame_serializer.sv
// Directed bench for hamming_frame_serializer: table of write bursts with an expected
// (tx_en, tx_bit) stream per bit period, plus hand sequences for latency, reset and gap writes.
module tb_hamming_frame_serializer;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int GAP     = 2;
`ifdef SER_SYNC_HDR_EN
    localparam int SYNC_BITS = 8;
    localparam int N6_TX     = 4;
    localparam int L3_LVL    = 3;
    localparam logic [7:0] SYNC_PAT = 8'hA5;
`else
    localparam int SYNC_BITS = 0;
    localparam int N6_TX     = 5;
    localparam int L3_LVL    = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] cw_in = '0;
    logic        cw_valid = 1'b0;
    logic        tx_bit, tx_en, bit_strobe, busy, overflow;
    logic [2:0]  fifo_level;

    hamming_frame_serializer #(
        .CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .GAP_BITS(GAP)
    ) dut (
        .clk(clk), .rst(rst), .cw_in(cw_in), .cw_valid(cw_valid),
        .tx_bit(tx_bit), .tx_en(tx_en), .bit_strobe(bit_strobe),
        .busy(busy), .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        int               n;      // words written on consecutive cycles
        logic [5:0][11:0] w;
        int               n_tx;   // words expected on the wire
        logic             ovf;
        int               lvl;    // fifo_level right after the last write edge
    } scen_t;

    int passed = 0;
    int total  = 0;

    // Monitor: one entry per bit period, plus hold/period sanity counters.
    logic [1:0] cap [$];
    logic [1:0] last_bit = '0;
    logic       prev_busy = 1'b0;
    int         since = 0;
    int         hold_err = 0;
    int         per_err = 0;

    always @(negedge clk) begin
        if (busy) begin
            if (bit_strobe) begin
                if (prev_busy && since != CLK_DIV) per_err++;
                cap.push_back({tx_en, tx_bit});
                last_bit = {tx_en, tx_bit};
                since = 1;
            end else begin
                if ({tx_en, tx_bit} != last_bit) hold_err++;
                since++;
            end
        end
        prev_busy = busy;
    end

    logic [1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic add_word(input logic [11:0] w);
        for (int b = 11; b >= 0; b--) exp_q.push_back({1'b1, w[b]});
    endtask

    task automatic add_gap();
        for (int g = 0; g < GAP; g++) exp_q.push_back(2'b00);
    endtask

    task automatic add_frame_start();
`ifdef SER_SYNC_HDR_EN
        for (int b = 7; b >= 0; b--) exp_q.push_back({1'b1, SYNC_PAT[b]});
`endif
    endtask

    task automatic wait_busy(input logic val, input int maxc, input string name);
        int n;
        n = 0;
        while (busy !== val && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, busy}, {31'd0, val});
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        cw_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk({name, "_outs"}, {24'd0, tx_bit, tx_en, bit_strobe, busy, overflow, fifo_level}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cmp_stream(input string name, input int base, input int h0, input int p0);
        int n, bad;
        n = cap.size() - base;
        chk({name, "_nbits"}, n, exp_q.size());
        bad = -1;
        for (int i = 0; i < n && i < exp_q.size(); i++)
            if (cap[base+i] !== exp_q[i] && bad < 0) bad = i;
        chk({name, "_first_bad_bit"}, bad, -1);
        chk({name, "_hold"}, hold_err - h0, 0);
        chk({name, "_period"}, per_err - p0, 0);
    endtask

    task automatic run_scen(input scen_t s);
        int base, h0, p0;
        base = cap.size(); h0 = hold_err; p0 = per_err;
        exp_q.delete();
        add_frame_start();
        for (int i = 0; i < s.n_tx; i++) add_word(s.w[i]);
        add_gap();
        for (int i = 0; i < s.n; i++) begin
            @(negedge clk);
            cw_valid = 1'b1;
            cw_in = s.w[i];
        end
        @(negedge clk);
        cw_valid = 1'b0;
        cw_in = '0;
        chk({s.name, "_level"}, fifo_level, s.lvl);
        chk({s.name, "_ovf_early"}, overflow, s.ovf);
        wait_busy(1'b1, 10, {s.name, "_start"});
        wait_busy(1'b0, 3000, {s.name, "_done"});
        cmp_stream(s.name, base, h0, p0);
        chk({s.name, "_ovf_end"}, overflow, s.ovf);
        chk({s.name, "_level_end"}, fifo_level, 0);
    endtask

    scen_t tbl [3];
    scen_t one;

    initial begin
        int base, h0, p0, n;

        tbl[0].name = "single";  tbl[0].n = 1; tbl[0].w = '0; tbl[0].w[0] = 12'hA5C;
        tbl[0].n_tx = 1; tbl[0].ovf = 1'b0; tbl[0].lvl = 1;
        tbl[1].name = "burst3";  tbl[1].n = 3; tbl[1].w = '0;
        tbl[1].w[0] = 12'hFFF; tbl[1].w[1] = 12'h000; tbl[1].w[2] = 12'h801;
        tbl[1].n_tx = 3; tbl[1].ovf = 1'b0; tbl[1].lvl = L3_LVL;
        tbl[2].name = "burst6";  tbl[2].n = 6; tbl[2].w = '0;
        tbl[2].w[0] = 12'h111; tbl[2].w[1] = 12'h222; tbl[2].w[2] = 12'h333;
        tbl[2].w[3] = 12'h444; tbl[2].w[4] = 12'h555; tbl[2].w[5] = 12'h666;
        tbl[2].n_tx = N6_TX; tbl[2].ovf = 1'b1; tbl[2].lvl = 4;

        repeat (2) @(negedge clk);
        for (int t = 0; t < 3; t++) begin
            do_reset({tbl[t].name, "_rst"});
            run_scen(tbl[t]);
        end

        // Latency, then reset mid-codeword and a clean follow-up frame.
        do_reset("lat_rst");
        @(negedge clk);
        cw_valid = 1'b1;
        cw_in = 12'hA5C;
        @(negedge clk);
        cw_valid = 1'b0;
        chk("lat_edgeE_strobe", {31'd0, bit_strobe}, 32'd0);
        @(negedge clk);
        chk("lat_edgeE1_strobe_en_bit", {29'd0, bit_strobe, tx_en, tx_bit}, 32'd7);
        repeat (SYNC_BITS * CLK_DIV + 18) @(negedge clk);
        chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_outs", {24'd0, tx_bit, tx_en, bit_strobe, busy, overflow, fifo_level}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        one.name = "post_rst"; one.n = 1; one.w = '0; one.w[0] = 12'h3C6;
        one.n_tx = 1; one.ovf = 1'b0; one.lvl = 1;
        run_scen(one);

        // Write landing in the first gap bit waits for IDLE, then starts its own frame.
        do_reset("gap_rst");
        base = cap.size(); h0 = hold_err; p0 = per_err;
        exp_q.delete();
        add_frame_start(); add_word(12'hA5C); add_gap();
        add_frame_start(); add_word(12'h0F0); add_gap();
        @(negedge clk);
        cw_valid = 1'b1;
        cw_in = 12'hA5C;
        @(negedge clk);
        cw_valid = 1'b0;
        n = 0;
        while (cap.size() - base < SYNC_BITS + 13 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("gap_reached", {31'd0, (cap.size() - base == SYNC_BITS + 13)}, 32'd1);
        chk("gap_tx_en", {31'd0, tx_en}, 32'd0);
        cw_valid = 1'b1;
        cw_in = 12'h0F0;
        @(negedge clk);
        cw_valid = 1'b0;
        wait_busy(1'b0, 200, "gap_idle");
        chk("gap_idle_level", fifo_level, 1);
        wait_busy(1'b1, 10, "gap_restart");
        wait_busy(1'b0, 2000, "gap_done");
        cmp_stream("gap", base, h0, p0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/hamming_frame_serializer.md
Name: hamming_frame_serializer

Overview:
Downstream stage of the Hamming encoder in the digital TX chain. Accepts 12-bit codewords on a one-cycle valid strobe and buffers them in a small FIFO. Emits the codewords as a framed, MSB-first serial bitstream at a fixed bit rate derived from the system clock, for the modulator stage.

Parameters:
CLK_DIV, 100, clock cycles per serial bit; legal range 2..65535.
FIFO_DEPTH, 4, codeword FIFO depth; must be a power of 2, minimum 2.
GAP_BITS, 2, idle bit periods inserted after each frame; legal range 1..255.
SYNC_WORD, 8'hA5, sync header pattern; used only when SER_SYNC_HDR_EN is defined.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
cw_in  input  12  codeword from encoder
cw_valid  input  1  codeword strobe; cw_in sampled on each clk edge where high
tx_bit  output  1  serial data bit
tx_en  output  1  high while tx_bit carries a frame bit
bit_strobe  output  1  one-cycle pulse on the first clock of every transmitted bit
busy  output  1  high in any state other than IDLE
overflow  output  1  sticky; set when a codeword is dropped because the FIFO is full
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous, immediate):
  - tx_bit=0, tx_en=0, bit_strobe=0, busy=0, overflow=0, fifo_level=0.
  - FIFO emptied, FSM set to IDLE, bit-period counter and bit index set to 0.
  - Reset mid-frame aborts the frame; no partial bits resume after release.
- FIFO write: on an edge with cw_valid=1.
  - Not full: push cw_in.
  - Full: drop cw_in and set overflow.
  - Full is judged on occupancy before any same-edge pop, so a write to a full FIFO is dropped even if a pop occurs on that edge.
  - overflow clears only on rst.
- FSM states: IDLE, SYNC (macro only), DATA, GAP.
- IDLE:
  - tx_en=0, tx_bit=0.
  - When the FIFO is non-empty at an edge, go to SYNC (macro defined), or to DATA and pop the head codeword into the shift register on that same edge (macro undefined).
- Bit timing:
  - The period counter runs 0..CLK_DIV-1 in SYNC, DATA and GAP.
  - tx_bit updates on the edge where the counter wraps to 0.
  - bit_strobe is high exactly during the cycle with counter=0.
  - Each bit lasts exactly CLK_DIV cycles.
- Latency: a codeword sampled with cw_valid on edge E into an empty, idle block produces its first bit_strobe in the cycle after edge E+1.
- DATA:
  - Shifts 12 bits, cw[11] first, tx_en=1.
  - After bit 0's period: if the FIFO is non-empty, pop the next codeword on the same edge and continue DATA with no gap. Otherwise go to GAP.
- GAP:
  - tx_en=0, tx_bit=0 for GAP_BITS bit periods, bit_strobe still pulsing.
  - Then IDLE. Words arriving during GAP start a new frame after the return to IDLE.
- busy = (state != IDLE).
- fifo_level reflects the registered occupancy after each edge.

Optional Feature:
Macro SER_SYNC_HDR_EN.
- Defined:
  - Each frame begins in SYNC, sending SYNC_WORD MSB first for 8 bit periods with tx_en=1.
  - The first codeword is popped on the edge that ends the last sync bit.
  - First bit_strobe latency is unchanged and belongs to the sync MSB.
- Undefined: the SYNC state and SYNC_WORD are absent, and frames start directly with codeword bits.

Test Plan:
- CLK_DIV=4, macro undefined, one write 12'hA5C → tx_bit sequence 1,0,1,0,0,1,0,1,1,1,0,0, each bit held 4 cycles with tx_en=1. Then 2 gap bits with tx_en=0, then busy=0. 14 bit_strobe pulses total.
- Same stimulus with macro defined → bits 1,0,1,0,0,1,0,1 (8'hA5) followed immediately by the 12 codeword bits. 22 strobes total.
- Three writes 12'hFFF, 12'h000, 12'h801 on consecutive cycles → one frame of 36 contiguous data bits with tx_en never dropping between words. overflow=0.
- Six writes on consecutive cycles, FIFO_DEPTH=4:
  - Macro undefined: 5 words transmitted, 6th dropped.
  - Macro defined: 4 words transmitted, last 2 dropped.
  - In both cases overflow=1 from the first dropped write and stays 1 until reset.
- Assert rst for 1 cycle mid-way through a codeword → all outputs 0 in the same cycle and the FIFO empty. A later write produces a clean frame from bit 11.
- Write during GAP → frame ends with GAP_BITS idle periods, busy drops for at least one IDLE cycle, then a new frame starts.
